systolic_tile_sequencer: RTL and testbench

- Run-time controller that sequences one MATRIX_SIZE x MATRIX_SIZE tile through the weight-stationary systolic array.
- Accepts a start request, then loads weight rows and streams data rows, each through its own valid/ready handshake.
- Drives the array's load_weight and enable controls and the input skewer's enable.
- Presents result rows with valid/ready backpressure, freezing the array while the consumer stalls. Sits between the host-side buffers and the array and skewer.

---
 rtl/systolic_tile_sequencer.sv | 96 +++++++++
 tb/tb_systolic_tile_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: sequences one weight-stationary tile through load, stream, flush and result drain
module systolic_tile_sequencer #(
  parameter int MATRIX_SIZE = 2,
  parameter int PIPE_LAT    = 2*MATRIX_SIZE,
  parameter int CNT_W       = $clog2(PIPE_LAT+MATRIX_SIZE+1),
  parameter int ROW_W       = $clog2(MATRIX_SIZE+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             weights_valid,
  output logic             weights_ready,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             load_weight,
  output logic             enable_mult,
  output logic             skew_enable,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [ROW_W-1:0] result_row,
  output logic             busy,
  output logic             finished
);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DONE} state_t;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(MATRIX_SIZE-1);
  localparam logic [ROW_W-1:0] ROWS = ROW_W'(MATRIX_SIZE);
  localparam logic [CNT_W-1:0] LAT  = CNT_W'(PIPE_LAT);
  state_t state, state_nx;
  logic [ROW_W-1:0] wcnt, dcnt, rcnt, wcnt_nx, dcnt_nx, rcnt_nx;
  logic [CNT_W-1:0] tick, tick_nx;
  logic stall, hs;
  always_comb begin
    result_valid  = (state == STREAM || state == FLUSH) && tick >= LAT && rcnt < ROWS;
    stall         = result_valid && !result_ready;
    hs            = result_valid && result_ready;
    start_ready   = state == IDLE;
    weights_ready = state == LOAD_W;
    load_weight   = weights_ready && weights_valid;
    data_ready    = state == STREAM && !stall;
    enable_mult   = (state == STREAM) ? data_valid && !stall :
                    (state == FLUSH)  ? !stall && rcnt < ROWS : 1'b0;
    skew_enable   = enable_mult;
    busy          = state != IDLE;
    finished      = state == DONE;
    result_row    = rcnt;
  end
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    dcnt_nx  = dcnt;
    rcnt_nx  = rcnt;
    tick_nx  = tick;
    case (state)
      IDLE: if (start_valid) begin
        state_nx = LOAD_W;
        wcnt_nx  = '0;
        dcnt_nx  = '0;
        rcnt_nx  = '0;
        tick_nx  = '0;
      end
      LOAD_W: if (weights_valid) begin
        wcnt_nx  = wcnt + 1'b1;
        state_nx = (wcnt == LAST) ? STREAM : LOAD_W;
      end
      STREAM, FLUSH: begin
        if (enable_mult) tick_nx = tick + 1'b1;
        if (state == STREAM && enable_mult) begin
          dcnt_nx  = dcnt + 1'b1;
          state_nx = (dcnt == LAST) ? FLUSH : STREAM;
        end
        // the final result handshake ends the tile even mid-advance
        if (hs) begin
          rcnt_nx = rcnt + 1'b1;
          if (rcnt == LAST) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wcnt  <= '0;
      dcnt  <= '0;
      rcnt  <= '0;
      tick  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      dcnt  <= dcnt_nx;
      rcnt  <= rcnt_nx;
      tick  <= tick_nx;
    end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb_systolic_tile_sequencer: two configurations driven in lockstep against a phase-level reference model
module tb_systolic_tile_sequencer;
  logic clk = 0, reset = 0;
  logic start_valid = 0, weights_valid = 0, data_valid = 0, result_ready = 0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N  = g == 0 ? 2 : 4;
    localparam int PL = g == 0 ? 4 : 2;
    localparam int RW = $clog2(N+1);
    logic sr, wr, lw, en, se, dr, rv, bz, fin;
    logic [RW-1:0] row;
    int ph, w, d, t, r;
    int fin_cnt = 0, fin_last = 0, st_cnt = 0, st_last = 0;
    logic e_rv, e_stl, e_en;
    systolic_tile_sequencer #(.MATRIX_SIZE(N), .PIPE_LAT(PL)) dut (
      .clk(clk), .reset(reset),
      .start_valid(start_valid), .start_ready(sr),
      .weights_valid(weights_valid), .weights_ready(wr),
      .data_valid(data_valid), .data_ready(dr),
      .load_weight(lw), .enable_mult(en), .skew_enable(se),
      .result_valid(rv), .result_ready(result_ready), .result_row(row),
      .busy(bz), .finished(fin)
    );
    // phases: 0 idle, 1 weights, 2 stream, 3 flush, 4 done
    assign e_rv  = (ph == 2 || ph == 3) && t >= PL && r < N;
    assign e_stl = e_rv && !result_ready;
    assign e_en  = ph == 2 ? (data_valid && !e_stl) : ph == 3 ? (!e_stl && r < N) : 1'b0;
    always @(posedge clk or negedge reset) begin : mdl
      int nph, nw, nd, nt, nr;
      if (!reset) begin
        ph <= 0; w <= 0; d <= 0; t <= 0; r <= 0;
      end else begin
        nph = ph; nw = w; nd = d; nt = t; nr = r;
        if (ph == 0 && start_valid) begin
          nph = 1; nw = 0; nd = 0; nt = 0; nr = 0;
        end else if (ph == 1 && weights_valid) begin
          nw = w + 1;
          if (nw == N) nph = 2;
        end else if (ph == 2 || ph == 3) begin
          if (e_en) begin
            nt = t + 1;
            if (ph == 2) begin
              nd = d + 1;
              if (nd == N) nph = 3;
            end
          end
          if (e_rv && result_ready) begin
            nr = r + 1;
            if (nr == N) nph = 4;
          end
        end else if (ph == 4) nph = 0;
        ph <= nph; w <= nw; d <= nd; t <= nt; r <= nr;
      end
    end
    always @(negedge clk) begin
      check($sformatf("c%0d_start_ready", g), sr, ph == 0);
      check($sformatf("c%0d_weights_ready", g), wr, ph == 1);
      check($sformatf("c%0d_load_weight", g), lw, ph == 1 && weights_valid);
      check($sformatf("c%0d_enable_mult", g), en, e_en);
      check($sformatf("c%0d_skew_enable", g), se, e_en);
      check($sformatf("c%0d_data_ready", g), dr, ph == 2 && !e_stl);
      check($sformatf("c%0d_result_valid", g), rv, e_rv);
      check($sformatf("c%0d_busy", g), bz, ph != 0);
      check($sformatf("c%0d_finished", g), fin, ph == 4);
      check($sformatf("c%0d_result_row", g), row, r);
      if (fin) begin fin_cnt <= fin_cnt + 1; fin_last <= cyc; end
      if (start_valid && sr) begin st_cnt <= st_cnt + 1; st_last <= cyc; end
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((cfg[0].bz || cfg[1].bz) && k < 100) begin step(); k++; end
    check("idle_timeout", k < 100, 1);
  endtask
  task automatic run_tile(input string name, input int dv_lo, input int dv_hi, input int rr_lo,
                          input int rr_hi, input bit hold, input int exp0, input int exp1);
    int c0, f0, f1, s0, rel;
    f0 = cfg[0].fin_cnt; f1 = cfg[1].fin_cnt; s0 = cfg[0].st_cnt;
    c0 = cyc; rel = 0;
    weights_valid = 1;
    while ((cfg[0].fin_cnt == f0 || cfg[1].fin_cnt == f1 || (hold && rel < 12)) && rel < 80) begin
      start_valid  = hold || rel == 0;
      data_valid   = !(rel >= dv_lo && rel <= dv_hi);
      result_ready = !(rel >= rr_lo && rel <= rr_hi);
      step(); rel++;
    end
    start_valid = 0; data_valid = 1; result_ready = 1;
    check({name, "_timeout"}, rel < 80, 1);
    check({name, "_fin0_latency"}, cfg[0].fin_last - c0, exp0);
    if (exp1 >= 0) check({name, "_fin1_latency"}, cfg[1].fin_last - c0, exp1);
    if (hold) begin
      check({name, "_starts"}, cfg[0].st_cnt - s0, 2);
      check({name, "_restart_cycle"}, cfg[0].st_last - c0, 10);
    end
    wait_idle();
  endtask
  initial begin
    int f0, f1;
    repeat (3) step();
    check("reset_start_ready", cfg[0].sr, 1);
    check("reset_busy", cfg[0].bz, 0);
    check("reset_row", cfg[0].row, 0);
    reset = 1;
    step();
    run_tile("s1_plain", -1, -1, -1, -1, 0, 9, 11);
    run_tile("s2_data_gap", 4, 6, -1, -1, 0, 12, 13);
    run_tile("s3_result_stall", -1, -1, 7, 11, 0, 14, 16);
    weights_valid = 1; data_valid = 1; result_ready = 1; start_valid = 1;
    step();
    start_valid = 0;
    repeat (3) step();
    check("s4_busy_before", cfg[0].bz, 1);
    f0 = cfg[0].fin_cnt; f1 = cfg[1].fin_cnt;
    reset = 0;
    #1;
    check("s4_async_start_ready", cfg[0].sr, 1);
    check("s4_async_busy", cfg[0].bz, 0);
    check("s4_async_enable", cfg[0].en, 0);
    check("s4_async_data_ready", cfg[0].dr, 0);
    repeat (2) step();
    reset = 1;
    repeat (3) step();
    check("s4_no_finish0", cfg[0].fin_cnt - f0, 0);
    check("s4_no_finish1", cfg[1].fin_cnt - f1, 0);
    run_tile("s4_after_reset", -1, -1, -1, -1, 0, 9, 11);
    run_tile("s5_start_held", -1, -1, -1, -1, 1, 9, 11);
    for (int i = 0; i < 600; i++) begin
      reset         = $urandom_range(0, 149) != 0;
      start_valid   = $urandom_range(0, 2) == 0;
      weights_valid = $urandom_range(0, 9) < 7;
      data_valid    = $urandom_range(0, 9) < 6;
      result_ready  = $urandom_range(0, 9) < 6;
      step();
    end
    reset = 1; start_valid = 0; weights_valid = 1; data_valid = 1; result_ready = 1;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
